pulse_train_generator: RTL



---
 rtl/pulse_generator_pkg.sv | 15 +
 rtl/pulse_train_channel.sv | 152 +++++++++++++++
 rtl/pulse_train_generator.sv | 70 +++++++
 3 files changed

// File: rtl/pulse_generator_pkg.sv
// Shared types and default sizing for the pulse generator family.
// Consumers: pulse_train_channel and pulse_train_generator.
package pulse_generator_pkg;

    typedef enum logic [1:0] {
        PT_IDLE   = 2'd0,
        PT_DELAY  = 2'd1,
        PT_ACTIVE = 2'd2,
        PT_GAP    = 2'd3
    } pt_state_e;

    localparam int PT_CNT_W_DEF       = 8;
    localparam int PT_RESET_DELAY_DEF = 10;

endpackage

// File: rtl/pulse_train_channel.sv
// One pulse-train channel: FSM, configuration latched at start, phase and pulse counters.
// Outputs are registered and follow the next-state decode.
module pulse_train_channel
    import pulse_generator_pkg::*;
#(
    parameter int CNT_W = PT_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] delay_cfg,
    input  logic [CNT_W-1:0] width_cfg,
    input  logic [CNT_W-1:0] gap_cfg,
    input  logic [CNT_W-1:0] count_cfg,
    output logic             pulse_out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAXV = {CNT_W{1'b1}};

    pt_state_e        state_r, state_s;
    logic [CNT_W-1:0] phase_cnt_r, phase_cnt_s;
    logic [CNT_W-1:0] pulse_cnt_r, pulse_cnt_s;
    logic [CNT_W-1:0] d_r, d_s, w_r, w_s, g_r, g_s, c_r, c_s;
    logic             pulse_r, busy_r, done_r, done_s;

    // A zero-length field still occupies one cycle, except the start delay.
    function automatic logic [CNT_W-1:0] last_cycle(input logic [CNT_W-1:0] len);
        if (len == ZERO) begin
            return ZERO;
        end else begin
            return len - ONE;
        end
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (val == MAXV) begin
            return MAXV;
        end else begin
            return val + ONE;
        end
    endfunction

    // Next-state, counter and configuration-latch decode.
    always_comb begin
        state_s     = state_r;
        phase_cnt_s = phase_cnt_r;
        pulse_cnt_s = pulse_cnt_r;
        d_s         = d_r;
        w_s         = w_r;
        g_s         = g_r;
        c_s         = c_r;
        done_s      = 1'b0;
        case (state_r)
            PT_IDLE: begin
                if (enable && start) begin
                    d_s         = delay_cfg;
                    w_s         = width_cfg;
                    g_s         = gap_cfg;
                    c_s         = count_cfg;
                    phase_cnt_s = ZERO;
                    pulse_cnt_s = ZERO;
                    state_s     = (delay_cfg == ZERO) ? PT_ACTIVE : PT_DELAY;
                end else begin
                    state_s = PT_IDLE;
                end
            end
            PT_DELAY: begin
                if (phase_cnt_r == last_cycle(d_r)) begin
                    phase_cnt_s = ZERO;
                    state_s     = PT_ACTIVE;
                end else begin
                    phase_cnt_s = phase_cnt_r + ONE;
                end
            end
            PT_ACTIVE: begin
                if (phase_cnt_r == last_cycle(w_r)) begin
                    phase_cnt_s = ZERO;
                    if ((c_r != ZERO) && ((pulse_cnt_r + ONE) == c_r)) begin
                        pulse_cnt_s = ZERO;
                        done_s      = 1'b1;
                        state_s     = PT_IDLE;
                    end else begin
                        pulse_cnt_s = sat_inc(pulse_cnt_r);
                        state_s     = PT_GAP;
                    end
                end else begin
                    phase_cnt_s = phase_cnt_r + ONE;
                end
            end
            PT_GAP: begin
                if (phase_cnt_r == last_cycle(g_r)) begin
                    phase_cnt_s = ZERO;
                    state_s     = PT_ACTIVE;
                end else begin
                    phase_cnt_s = phase_cnt_r + ONE;
                end
            end
            default: begin
                phase_cnt_s = ZERO;
                pulse_cnt_s = ZERO;
                state_s     = PT_IDLE;
            end
        endcase
        // Abort wins over everything once a train is running.
        if (abort && (state_r != PT_IDLE)) begin
            state_s     = PT_IDLE;
            phase_cnt_s = ZERO;
            pulse_cnt_s = ZERO;
            done_s      = 1'b1;
        end else begin
            done_s = done_s;
        end
    end

    // State, counters, latched configuration and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= PT_IDLE;
            phase_cnt_r <= ZERO;
            pulse_cnt_r <= ZERO;
            d_r         <= ZERO;
            w_r         <= ZERO;
            g_r         <= ZERO;
            c_r         <= ZERO;
            pulse_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            phase_cnt_r <= phase_cnt_s;
            pulse_cnt_r <= pulse_cnt_s;
            d_r         <= d_s;
            w_r         <= w_s;
            g_r         <= g_s;
            c_r         <= c_s;
            pulse_r     <= (state_s == PT_ACTIVE);
            busy_r      <= (state_s != PT_IDLE);
            done_r      <= done_s;
        end
    end

    assign pulse_out = pulse_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: rtl/pulse_train_generator.sv
// Multi-channel pulse train generator: shared post-reset ready counter plus NUM_CH channels.
// Optional per-channel abort input when PULSE_TRAIN_ABORT_EN is defined.
module pulse_train_generator
    import pulse_generator_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = PT_CNT_W_DEF,
    parameter int RESET_DELAY = PT_RESET_DELAY_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH*CNT_W-1:0] delay_cfg,
    input  logic [NUM_CH*CNT_W-1:0] width_cfg,
    input  logic [NUM_CH*CNT_W-1:0] gap_cfg,
    input  logic [NUM_CH*CNT_W-1:0] count_cfg,
`ifdef PULSE_TRAIN_ABORT_EN
    input  logic [NUM_CH-1:0]       abort,
`endif
    output logic [NUM_CH-1:0]       pulse_out,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done,
    output logic                    ready_after_reset
);

    localparam int RDY_W = $clog2(RESET_DELAY + 1);

    logic [RDY_W-1:0]  ready_cnt_r;
    logic              ready_r;
    logic [NUM_CH-1:0] abort_s;

`ifdef PULSE_TRAIN_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = {NUM_CH{1'b0}};
`endif

    // Ready counter: freezes once ready so it never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_cnt_r <= {RDY_W{1'b0}};
            ready_r     <= 1'b0;
        end else if (!ready_r) begin
            ready_cnt_r <= ready_cnt_r + RDY_W'(1);
            ready_r     <= (ready_cnt_r == RDY_W'(RESET_DELAY - 1));
        end
    end

    assign ready_after_reset = ready_r;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pulse_train_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .enable    (ready_r),
            .start     (start[g]),
            .abort     (abort_s[g]),
            .delay_cfg (delay_cfg[g*CNT_W +: CNT_W]),
            .width_cfg (width_cfg[g*CNT_W +: CNT_W]),
            .gap_cfg   (gap_cfg[g*CNT_W +: CNT_W]),
            .count_cfg (count_cfg[g*CNT_W +: CNT_W]),
            .pulse_out (pulse_out[g]),
            .busy      (busy[g]),
            .done      (done[g])
        );
    end

endmodule
